seq_pattern_detect_multi: RTL and testbench
===========================================

// Module: seq_pattern_detect_multi
// PURPOSE
//   Serial bit-stream detector with N_PAT run-time programmable patterns,
//     each up to MAX_LEN bits, plus a "run of >= RUN_MIN ones" detector.
//   Sits on the single-bit signal channel and drives the outlet code and led.
//   Generalises the fixed 101 / 1011 / 111+ detector: pattern set, lengths,
//     overlap mode and run threshold are all configurable.
// PARAMETERS
//   N_PAT   4   number of pattern slots (>=1)
//   MAX_LEN 8   max pattern length and history depth in bits (>=2)
//   RUN_MIN 3   consecutive-ones threshold for run_hit (2..MAX_LEN)
//   CNT_W   16  hit-counter width (used only with SEQ_HIT_COUNT_EN)
// PORTS
//   clk          in  1        clock, rising edge
//   rst          in  1        asynchronous, active-low reset
//   signal       in  1        serial data bit
//   in_valid     in  1        signal is sampled only when 1
//   overlap_en   in  1        1 = overlapping matches, 0 = history flushed after a match
//   cfg_we       in  1        write pattern slot cfg_idx
//   cfg_idx      in  IW       slot index, IW = $clog2(N_PAT) (min 1)
//   cfg_pattern  in  MAX_LEN  pattern bits; bit len-1 is received first, bit 0 last
//   cfg_len      in  LW       pattern length, LW = $clog2(MAX_LEN+1); 0 disables the slot
//   match        out N_PAT    per-slot match flags, registered
//   run_hit      out 1        run of ones >= RUN_MIN, registered
//   match_valid  out 1        1-cycle pulse: match/run_hit/outlet updated from a sample
//   outlet       out CW       result code, CW = $clog2(N_PAT+2)
//   led          out 1        last sampled signal bit, registered
//   cnt_idx      in  IW       hit-counter read select
//   cnt_clr      in  1        synchronous clear of all hit counters
//   cnt_data     out CNT_W    hit count of slot cnt_idx (combinational read)
// BEHAVIOUR
//   Reset: hist=0, fill=0, run=0, all slots len=0/pattern=0, match=0, run_hit=0,
//     match_valid=0, outlet=CODE_NONE, led=0, counters=0.
//   On in_valid=1 at a clock edge:
//     - hist_n = {hist[MAX_LEN-2:0], signal}; fill_n = min(fill+1, MAX_LEN).
//     - run_n = signal ? min(run+1, MAX_LEN) : 0.
//     - Slot i hits if len_i!=0, fill_n>=len_i, and hist_n[len_i-1:0]==pat_i[len_i-1:0].
//     - match <= hits; run_hit <= (run_n>=RUN_MIN); match_valid <= 1; led <= signal.
//     - outlet <= lowest-index hit i; else CODE_RUN (=N_PAT) if run_hit;
//       else CODE_NONE (=N_PAT+1). Lower slot indices have priority.
//     - overlap_en=0 and any slot hit: fill<=0, run<=0 (hist shifts normally);
//       run_hit alone does not flush.
//   Latency: 1 cycle from the sampling edge to match/outlet/match_valid.
//   in_valid=0: hist/fill/run hold; match_valid<=0; match, run_hit, outlet, led hold.
//   cfg_we: slot cfg_idx updated at the edge; a sample on the same edge compares
//     against the OLD slot contents. cfg_idx>=N_PAT: write ignored.
//     cfg_len>MAX_LEN is clamped to MAX_LEN. History is not flushed on cfg writes.
//   Run counter and fill saturate at MAX_LEN; no wrap-around.
//   Reset asserted mid-stream: all state to reset values immediately (async).
// CONFIGURATION
//   `SEQ_HIT_COUNT_EN defined: per-slot saturating CNT_W counters, +1 on each slot
//     hit; cnt_clr clears all (clear wins over an increment on the same edge);
//     cnt_data = count[cnt_idx], 0 when cnt_idx>=N_PAT.
//   Not defined: no counters synthesised; cnt_data tied to 0; cnt_idx, cnt_clr unused.
//   Port list is identical in both builds.
// STRUCTURE
//   seq_det_pkg.vh: CODE_RUN/CODE_NONE derivation, IW/LW/CW width functions,
//     length-mask function mask(len) = (1<<len)-1.
//   Sub-module seq_pat_slot: one pattern/length register pair plus masked
//     compare against hist_n and fill_n. Instantiated N_PAT times in a generate loop.
//   Top level: history/fill/run registers, priority encoder, output registers, counters.
// TESTING (defaults N_PAT=4, MAX_LEN=8, RUN_MIN=3)
//   1 Reset, no slots programmed, stream 1,0,1 -> match=0000, outlet=5 (NONE) each pulse.
//   2 slot0=1011/len4, slot1=101/len3, overlap_en=1, stream 1,0,1,1 -> 3rd pulse
//     match=0010 outlet=1; 4th match=0001 outlet=0.
//   3 Same slots, overlap_en=0, stream 1,0,1,0,1 -> hit on bit 3 (outlet=1);
//     bit 5 gives no hit (fill=2 < 3), outlet=5.
//   4 No slots, stream 1,1,1,1,0 -> outlet 5,5,4,4,5; run_hit 0,0,1,1,0.
//   5 cfg_we writing slot1=101 on the same edge as the 3rd bit of 1,0,1 -> no hit;
//     next 0,1 -> hit (outlet=1); in_valid=0 gaps hold outlet, match_valid=0.
//   6 SEQ_HIT_COUNT_EN: 3 hits on slot1, cnt_idx=1 -> cnt_data=3; cnt_clr -> 0;
//     reset mid-stream -> all outputs 0 except outlet=5.

Source files
------------

// File: rtl/seq_pattern_detect_multi_pkg.sv
// Shared helpers for the programmable serial pattern detector: width
// derivations, result-code values and the pattern length mask.
package seq_pattern_detect_multi_pkg;

  localparam int unsigned MASK_W = 32;

  function automatic int unsigned iw_f(input int unsigned n_pat);
    return (n_pat <= 2) ? 1 : $clog2(n_pat);
  endfunction

  function automatic int unsigned lw_f(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned cw_f(input int unsigned n_pat);
    return $clog2(n_pat + 2);
  endfunction

  function automatic int unsigned code_run_f(input int unsigned n_pat);
    return n_pat;
  endfunction

  function automatic int unsigned code_none_f(input int unsigned n_pat);
    return n_pat + 1;
  endfunction

  // (1 << len) - 1, built bitwise so len == MASK_W cannot overflow
  function automatic logic [MASK_W-1:0] mask_f(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) m[i] = (i < len);
    return m;
  endfunction

endpackage

// File: rtl/seq_pattern_detect_multi_slot.sv
// One programmable pattern slot: pattern/length registers and a masked
// compare of the low len bits of the incoming history.
module seq_pattern_detect_multi_slot
  import seq_pattern_detect_multi_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [MAX_LEN-1:0]          wr_pattern,
  input  logic [lw_f(MAX_LEN)-1:0]    wr_len,
  input  logic [MAX_LEN-1:0]          hist_n,
  input  logic [lw_f(MAX_LEN)-1:0]    fill_n,
  output logic                        hit_c
);

  localparam int unsigned LW = lw_f(MAX_LEN);

  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic [LW-1:0]      len_clamped_c;
  logic [MAX_LEN-1:0] mask_c;

  assign len_clamped_c = (wr_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : wr_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat <= '0;
      len <= '0;
    end else if (we) begin
      pat <= wr_pattern;
      len <= len_clamped_c;
    end
  end

  // Compare uses the registered (old) contents, so a write never affects
  // a sample taken on the same edge.
  assign mask_c = MAX_LEN'(mask_f(32'(len)));
  assign hit_c  = (len != '0) && (fill_n >= len) &&
                  (((hist_n ^ pat) & mask_c) == '0);

endmodule

// File: rtl/seq_pattern_detect_multi.sv
// Serial detector with N_PAT programmable patterns plus a run-of-ones detector.
// Optional per-slot hit counters are built when SEQ_HIT_COUNT_EN is defined.
module seq_pattern_detect_multi
  import seq_pattern_detect_multi_pkg::*;
#(
  parameter int unsigned N_PAT   = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned RUN_MIN = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signal,
  input  logic                      in_valid,
  input  logic                      overlap_en,
  input  logic                      cfg_we,
  input  logic [iw_f(N_PAT)-1:0]    cfg_idx,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [lw_f(MAX_LEN)-1:0]  cfg_len,
  output logic [N_PAT-1:0]          match,
  output logic                      run_hit,
  output logic                      match_valid,
  output logic [cw_f(N_PAT)-1:0]    outlet,
  output logic                      led,
  input  logic [iw_f(N_PAT)-1:0]    cnt_idx,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          cnt_data
);

  localparam int unsigned IW = iw_f(N_PAT);
  localparam int unsigned LW = lw_f(MAX_LEN);
  localparam int unsigned CW = cw_f(N_PAT);
  localparam logic [CW-1:0] CODE_RUN  = CW'(code_run_f(N_PAT));
  localparam logic [CW-1:0] CODE_NONE = CW'(code_none_f(N_PAT));

  // Only MAX_LEN-1 bits are kept; the oldest bit falls off on the next shift.
  logic [MAX_LEN-2:0] hist;
  logic [LW-1:0]      fill;
  logic [LW-1:0]      run;

  logic [MAX_LEN-1:0] hist_n_c;
  logic [LW-1:0]      fill_n_c;
  logic [LW-1:0]      run_n_c;
  logic [N_PAT-1:0]   hits_c;
  logic               run_hit_n_c;
  logic [CW-1:0]      outlet_n_c;

  assign hist_n_c    = {hist, signal};
  assign fill_n_c    = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
  assign run_n_c     = signal ? ((run == LW'(MAX_LEN)) ? run : run + LW'(1)) : '0;
  assign run_hit_n_c = (run_n_c >= LW'(RUN_MIN));

  for (genvar g = 0; g < N_PAT; g++) begin : g_slot
    seq_pattern_detect_multi_slot #(
      .MAX_LEN (MAX_LEN)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .we         (cfg_we && (cfg_idx == IW'(g))),
      .wr_pattern (cfg_pattern),
      .wr_len     (cfg_len),
      .hist_n     (hist_n_c),
      .fill_n     (fill_n_c),
      .hit_c      (hits_c[g])
    );
  end

  // Lowest-index hit wins, then the run detector, then "no result".
  always_comb begin
    outlet_n_c = run_hit_n_c ? CODE_RUN : CODE_NONE;
    for (int i = int'(N_PAT) - 1; i >= 0; i--) begin
      if (hits_c[i]) outlet_n_c = CW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist        <= '0;
      fill        <= '0;
      run         <= '0;
      match       <= '0;
      run_hit     <= 1'b0;
      match_valid <= 1'b0;
      outlet      <= CODE_NONE;
      led         <= 1'b0;
    end else if (in_valid) begin
      hist <= hist_n_c[MAX_LEN-2:0];
      if (!overlap_en && (|hits_c)) begin
        fill <= '0;
        run  <= '0;
      end else begin
        fill <= fill_n_c;
        run  <= run_n_c;
      end
      match       <= hits_c;
      run_hit     <= run_hit_n_c;
      match_valid <= 1'b1;
      outlet      <= outlet_n_c;
      led         <= signal;
    end else begin
      match_valid <= 1'b0;
    end
  end

`ifdef SEQ_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt [N_PAT];

  // Saturating per-slot hit counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_PAT); i++) cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < int'(N_PAT); i++) cnt[i] <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < int'(N_PAT); i++) begin
        if (hits_c[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign cnt_data = (32'(cnt_idx) < N_PAT) ? cnt[cnt_idx] : '0;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_idx, cnt_clr};
  assign cnt_data   = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detect_multi.sv
// Self-checking bench for seq_pattern_detect_multi (both SEQ_HIT_COUNT_EN builds).
module tb_seq_pattern_detect_multi;

  localparam int N_PAT   = 4;
  localparam int MAX_LEN = 8;
  localparam int RUN_MIN = 3;
  localparam int CNT_W   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        signal, in_valid, overlap_en, cfg_we, cnt_clr;
  logic [1:0]  cfg_idx, cnt_idx;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [3:0]  match;
  logic        run_hit, match_valid, led;
  logic [2:0]  outlet;
  logic [15:0] cnt_data;

  always #5 clk = ~clk;

  seq_pattern_detect_multi #(
    .N_PAT(N_PAT), .MAX_LEN(MAX_LEN), .RUN_MIN(RUN_MIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .signal(signal), .in_valid(in_valid),
    .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .match(match),
    .run_hit(run_hit), .match_valid(match_valid), .outlet(outlet), .led(led),
    .cnt_idx(cnt_idx), .cnt_clr(cnt_clr), .cnt_data(cnt_data)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Behavioural model: bits since last flush, run length, slot table.
  int m_pat [N_PAT];
  int m_len [N_PAT];
  int m_cnt [N_PAT];
  int m_hist, m_fill, m_run;
  int e_match, e_run_hit, e_mv, e_outlet, e_led;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_PAT; i++) begin
      m_pat[i] = 0; m_len[i] = 0; m_cnt[i] = 0;
    end
    m_hist = 0; m_fill = 0; m_run = 0;
    e_match = 0; e_run_hit = 0; e_mv = 0; e_outlet = N_PAT + 1; e_led = 0;
  endtask

  task automatic model_edge(input int s, input int v, input int we, input int idx,
                            input int p, input int l, input int clr, input int ov);
    int nh, nf, nr, hits, low;
    bit found;
    if (v != 0) begin
      nh = ((m_hist << 1) | s) & ((1 << MAX_LEN) - 1);
      nf = (m_fill + 1 > MAX_LEN) ? MAX_LEN : m_fill + 1;
      nr = (s != 0) ? ((m_run + 1 > MAX_LEN) ? MAX_LEN : m_run + 1) : 0;
      hits = 0;
      for (int i = 0; i < N_PAT; i++) begin
        low = (1 << m_len[i]) - 1;
        if (m_len[i] != 0 && nf >= m_len[i] && (nh & low) == (m_pat[i] & low))
          hits |= (1 << i);
      end
      found = 1'b0;
      e_outlet = (nr >= RUN_MIN) ? N_PAT : N_PAT + 1;
      for (int i = 0; i < N_PAT; i++) begin
        if (!found && hits[i]) begin
          e_outlet = i; found = 1'b1;
        end
      end
      e_match = hits; e_run_hit = (nr >= RUN_MIN); e_mv = 1; e_led = s;
      m_hist = nh;
      if (ov == 0 && hits != 0) begin
        m_fill = 0; m_run = 0;
      end else begin
        m_fill = nf; m_run = nr;
      end
`ifdef SEQ_HIT_COUNT_EN
      for (int i = 0; i < N_PAT; i++)
        if (hits[i] && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
`endif
    end else begin
      e_mv = 0;
    end
`ifdef SEQ_HIT_COUNT_EN
    if (clr != 0) for (int i = 0; i < N_PAT; i++) m_cnt[i] = 0;
`endif
    if (we != 0 && idx < N_PAT) begin
      m_pat[idx] = p & ((1 << MAX_LEN) - 1);
      m_len[idx] = (l > MAX_LEN) ? MAX_LEN : l;
    end
  endtask

  function automatic int exp_cnt(input int idx);
`ifdef SEQ_HIT_COUNT_EN
    return (idx < N_PAT) ? m_cnt[idx] : 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst)
      model_edge(int'(signal), int'(in_valid), int'(cfg_we), int'(cfg_idx),
                 int'(cfg_pattern), int'(cfg_len), int'(cnt_clr), int'(overlap_en));
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("match",       int'(match),       e_match);
      chk("run_hit",     int'(run_hit),     e_run_hit);
      chk("match_valid", int'(match_valid), e_mv);
      chk("outlet",      int'(outlet),      e_outlet);
      chk("led",         int'(led),         e_led);
      chk("cnt_data",    int'(cnt_data),    exp_cnt(int'(cnt_idx)));
    end
  end

  task automatic step(input int s, input int v, input int we = 0, input int idx = 0,
                      input int p = 0, input int l = 0, input int clr = 0);
    @(negedge clk); #1;
    signal = s[0]; in_valid = v[0]; cfg_we = we[0]; cfg_idx = 2'(idx);
    cfg_pattern = 8'(p); cfg_len = 4'(l); cnt_clr = clr[0];
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic prog(input int idx, input int p, input int l);
    step(0, 0, 1, idx, p, l);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  int t4_bits [5] = '{1, 1, 1, 1, 0};
  int t4_out  [5] = '{5, 5, 4, 4, 5};
  int t4_run  [5] = '{0, 0, 1, 1, 0};

  initial begin
    rst = 1'b0; signal = 1'b0; in_valid = 1'b0; overlap_en = 1'b1; cfg_we = 1'b0;
    cfg_idx = '0; cfg_pattern = '0; cfg_len = '0; cnt_idx = '0; cnt_clr = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    chk("reset_outlet", int'(outlet), 5);
    chk("reset_match",  int'(match),  0);

    // 1: no slots programmed
    step(1, 1); chk("t1_outlet0", int'(outlet), 5);
    step(0, 1); chk("t1_outlet1", int'(outlet), 5);
    step(1, 1); chk("t1_outlet2", int'(outlet), 5); chk("t1_mv", int'(match_valid), 1);

    // 2: overlapping 1011 / 101
    do_reset();
    prog(0, 'b1011, 4); prog(1, 'b101, 3); overlap_en = 1'b1;
    step(1, 1); step(0, 1); step(1, 1);
    chk("t2_match3", int'(match), 'b0010); chk("t2_outlet3", int'(outlet), 1);
    step(1, 1);
    chk("t2_match4", int'(match), 'b0001); chk("t2_outlet4", int'(outlet), 0);

    // 3: non-overlapping flush
    do_reset();
    prog(0, 'b1011, 4); prog(1, 'b101, 3); overlap_en = 1'b0;
    step(1, 1); step(0, 1); step(1, 1);
    chk("t3_outlet3", int'(outlet), 1);
    step(0, 1); step(1, 1);
    chk("t3_outlet5", int'(outlet), 5); chk("t3_match5", int'(match), 0);

    // 4: run of ones
    do_reset(); overlap_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(t4_bits[i], 1);
      chk("t4_outlet", int'(outlet), t4_out[i]);
      chk("t4_run_hit", int'(run_hit), t4_run[i]);
    end

    // 5: config write on the sampling edge uses old slot contents
    do_reset();
    step(1, 1); step(0, 1);
    step(1, 1, 1, 1, 'b101, 3);
    chk("t5_nohit_outlet", int'(outlet), 5); chk("t5_nohit_match", int'(match), 0);
    step(0, 1); step(1, 1);
    chk("t5_hit_outlet", int'(outlet), 1);
    step(0, 0); step(0, 0);
    chk("t5_gap_outlet", int'(outlet), 1); chk("t5_gap_mv", int'(match_valid), 0);

    // 6: hit counter, clear, mid-stream reset
    step(0, 1); step(1, 1); step(0, 1); step(1, 1);
    cnt_idx = 2'd1; #1;
`ifdef SEQ_HIT_COUNT_EN
    chk("t6_cnt3", int'(cnt_data), 3);
`else
    chk("t6_cnt_tied", int'(cnt_data), 0);
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t6_cnt_clr", int'(cnt_data), 0);
    step(0, 1); step(1, 1);
`ifdef SEQ_HIT_COUNT_EN
    chk("t6_cnt1", int'(cnt_data), 1);
`else
    chk("t6_cnt1_tied", int'(cnt_data), 0);
`endif
    step(1, 1); step(1, 1);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_match",  int'(match), 0);
    chk("t6_rst_runhit", int'(run_hit), 0);
    chk("t6_rst_mv",     int'(match_valid), 0);
    chk("t6_rst_outlet", int'(outlet), 5);
    chk("t6_rst_led",    int'(led), 0);
    chk("t6_rst_cnt",    int'(cnt_data), 0);
    @(negedge clk); #1;
    rst = 1'b1;

    // 7: length clamp to MAX_LEN, run/fill saturation
    overlap_en = 1'b1;
    prog(2, 'hFF, 15);
    for (int i = 0; i < 7; i++) step(1, 1);
    chk("t7_outlet7", int'(outlet), 4);
    step(1, 1);
    chk("t7_outlet8", int'(outlet), 2); chk("t7_match8", int'(match), 'b0100);
    step(1, 1);
    chk("t7_outlet9", int'(outlet), 2);
    step(0, 1);
    chk("t7_outlet10", int'(outlet), 5);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
